// File: rtl/rps_referee.sv
// Rock-Paper-Scissors round controller: locks the computer's choice generator,
// samples its throw, judges each round and keeps match score up to WIN_TARGET.
module rps_referee #(
  parameter int WIN_TARGET  = 3,
  parameter int SCORE_W     = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_RETRY   = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         player_choice,
  input  logic               player_commit,
  input  logic               new_match,
  input  logic [1:0]         computer_choice,
  output logic               stop_signal,
  output logic [1:0]         result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] computer_score,
  output logic [SCORE_W-1:0] round_count,
  output logic               busy,
  output logic               match_over,
  output logic               match_winner
);

  // The cycle counter serves both the LOCK hold window and the 2-cycle REARM gap.
  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOCK  = 3'd1,
    S_REARM = 3'd2,
    S_JUDGE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [1:0]         throw_q, throw_d;
  logic [1:0]         capt_q, capt_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;
  logic               over_q, over_d;
  logic               winner_q, winner_d;
  logic [1:0]         result_q, result_d;
  logic               rv_q, rv_d;
  logic [SCORE_W-1:0] pscore_q, pscore_d;
  logic [SCORE_W-1:0] cscore_q, cscore_d;
  logic [SCORE_W-1:0] rounds_q, rounds_d;
  logic [1:0]         judged_s;

  // Round outcome: an Unset computer throw is a void round.
  function automatic logic [1:0] judge_throw(input logic [1:0] p, input logic [1:0] c);
    logic [1:0] r;
    if ((c == 2'd0) || (p == 2'd0)) begin
      r = 2'd0;
    end else if (p == c) begin
      r = 2'd3;
    end else begin
      case ({p, c})
        4'b01_11, 4'b10_01, 4'b11_10: r = 2'd1;
        default:                      r = 2'd2;
      endcase
    end
    return r;
  endfunction

  assign judged_s = judge_throw(throw_q, capt_q);

  // Next-state and next-output logic for the round FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    throw_d  = throw_q;
    capt_d   = capt_q;
    winner_d = winner_q;
    result_d = result_q;
    rv_d     = 1'b0;
    pscore_d = pscore_q;
    cscore_d = cscore_q;
    rounds_d = rounds_q;

    if (new_match) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      retry_d  = '0;
      capt_d   = 2'd0;
      winner_d = 1'b0;
      result_d = 2'd0;
      pscore_d = '0;
      cscore_d = '0;
      rounds_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (player_commit && (player_choice != 2'd0)) begin
            throw_d = player_choice;
            cnt_d   = '0;
            state_d = S_LOCK;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_LOCK: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_d  = '0;
            capt_d = computer_choice;
            if (computer_choice != 2'd0) begin
              state_d = S_JUDGE;
            end else if (retry_q < RTY_W'(MAX_RETRY)) begin
              retry_d = retry_q + RTY_W'(1);
              state_d = S_REARM;
            end else begin
              // Retries exhausted: the Unset capture judges as a void round.
              state_d = S_JUDGE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_REARM: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_LOCK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_JUDGE: begin
          result_d = judged_s;
          rv_d     = 1'b1;
          retry_d  = '0;
          case (judged_s)
            2'd1:    pscore_d = pscore_q + SCORE_W'(1);
            2'd2:    cscore_d = cscore_q + SCORE_W'(1);
            default: pscore_d = pscore_q;
          endcase
          if ((judged_s != 2'd0) && (rounds_q != {SCORE_W{1'b1}})) begin
            rounds_d = rounds_q + SCORE_W'(1);
          end else begin
            rounds_d = rounds_q;
          end
          if (pscore_d == SCORE_W'(WIN_TARGET)) begin
            winner_d = 1'b0;
            state_d  = S_DONE;
          end else if (cscore_d == SCORE_W'(WIN_TARGET)) begin
            winner_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Status outputs are registered from the next state so they align with it.
    stop_d = (state_d == S_LOCK);
    busy_d = (state_d == S_LOCK) || (state_d == S_REARM) || (state_d == S_JUDGE);
    over_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      throw_q  <= 2'd0;
      capt_q   <= 2'd0;
      stop_q   <= 1'b0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
      result_q <= 2'd0;
      rv_q     <= 1'b0;
      pscore_q <= '0;
      cscore_q <= '0;
      rounds_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      throw_q  <= throw_d;
      capt_q   <= capt_d;
      stop_q   <= stop_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      pscore_q <= pscore_d;
      cscore_q <= cscore_d;
      rounds_q <= rounds_d;
    end
  end

  assign stop_signal    = stop_q;
  assign result         = result_q;
  assign result_valid   = rv_q;
  assign player_score   = pscore_q;
  assign computer_score = cscore_q;
  assign round_count    = rounds_q;
  assign busy           = busy_q;
  assign match_over     = over_q;
  assign match_winner   = winner_q;

endmodule

// File: tb/tb_rps_referee.sv
// Directed plus randomized bench for rps_referee, checked against a
// round-level reference model of the game rules.
module tb_rps_referee;
  localparam int WIN = 3;
  localparam int SW  = 4;
  localparam int H   = 4;
  localparam int MR  = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    player_choice = 2'd0;
  logic          player_commit = 1'b0;
  logic          new_match = 1'b0;
  logic [1:0]    computer_choice = 2'd0;
  logic          stop_signal;
  logic [1:0]    result;
  logic          result_valid;
  logic [SW-1:0] player_score, computer_score, round_count;
  logic          busy, match_over, match_winner;

  always #5 clock = ~clock;

  rps_referee #(.WIN_TARGET(WIN), .SCORE_W(SW), .HOLD_CYCLES(H), .MAX_RETRY(MR)) dut (
    .clock(clock), .reset_n(reset_n), .player_choice(player_choice),
    .player_commit(player_commit), .new_match(new_match),
    .computer_choice(computer_choice), .stop_signal(stop_signal), .result(result),
    .result_valid(result_valid), .player_score(player_score),
    .computer_score(computer_score), .round_count(round_count), .busy(busy),
    .match_over(match_over), .match_winner(match_winner)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_ps, m_cs, m_rc, m_res, m_over, m_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ps = 0; m_cs = 0; m_rc = 0; m_res = 0; m_over = 0; m_win = 0;
  endtask

  // Cyclic rule: player beats the throw one step below it (mod 3).
  function automatic int ref_result(input int p, input int c);
    int d;
    if (c == 0) return 0;
    d = (p - c + 3) % 3;
    if (d == 0) return 3;
    if (d == 1) return 1;
    return 2;
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, "_result"}, result, m_res);
    chk({tag, "_pscore"}, player_score, m_ps);
    chk({tag, "_cscore"}, computer_score, m_cs);
    chk({tag, "_rounds"}, round_count, m_rc);
    chk({tag, "_over"}, match_over, m_over);
    chk({tag, "_winner"}, match_winner, m_win);
  endtask

  function automatic logic [1:0] rnd2(input int lo);
    return 2'($urandom_range(3, lo));
  endfunction

  // Plays one round; vals are the generator's values for successive LOCK windows.
  task automatic play(input int p, input int v0, input int v1, input int v2, input int v3,
                      input bit poke);
    int vals[4];
    int w, windows, cap, exp_res, exp_k, rv_seen, rv_k, widx;
    bit in_win;
    vals = '{v0, v1, v2, v3};
    w = 0;
    while (w < MR && vals[w] == 0) w++;
    windows = w + 1;
    cap     = vals[w];
    exp_res = ref_result(p, cap);
    exp_k   = 5 + (windows - 1) * (H + 2);
    rv_seen = 0;
    rv_k    = -1;
    player_choice = 2'(p);
    player_commit = 1'b1;
    @(negedge clock);
    player_commit = 1'b0;
    player_choice = rnd2(0);
    for (int k = 0; k <= exp_k + 2; k++) begin
      in_win = 1'b0;
      widx   = 0;
      for (int j = 0; j < windows; j++) begin
        if (k >= j * (H + 2) && k < j * (H + 2) + H) begin
          in_win = 1'b1;
          widx   = j;
        end
      end
      computer_choice = in_win ? 2'(vals[widx]) : rnd2(0);
      chk("stop_cycle", stop_signal, in_win);
      if (result_valid === 1'b1) begin
        rv_seen++;
        rv_k = k;
      end
      if (k == 0) chk("busy_in_round", busy, 1);
      if (poke && (k == 1 || k == exp_k - 1)) begin
        player_choice = rnd2(1);
        player_commit = 1'b1;
      end else begin
        player_commit = 1'b0;
      end
      if (k == exp_k) begin
        m_res = exp_res;
        if (exp_res == 1) m_ps++;
        if (exp_res == 2) m_cs++;
        if (exp_res != 0 && m_rc < (1 << SW) - 1) m_rc++;
        if (m_ps == WIN || m_cs == WIN) begin
          m_over = 1;
          m_win  = (m_cs == WIN) ? 1 : 0;
        end
        chk("busy_at_result", busy, 0);
        chk_status("round");
      end
      @(negedge clock);
    end
    player_commit = 1'b0;
    chk("result_valid_count", rv_seen, 1);
    chk("result_latency", rv_k, exp_k);
  endtask

  task automatic pulse_new_match(input bit with_commit);
    new_match = 1'b1;
    if (with_commit) begin
      player_choice = 2'd1;
      player_commit = 1'b1;
    end
    @(negedge clock);
    new_match     = 1'b0;
    player_commit = 1'b0;
    model_clear();
    chk_status("new_match");
    chk("new_match_stop", stop_signal, 0);
  endtask

  // Watches n cycles and checks nothing starts.
  task automatic expect_quiet(input string tag, input int n);
    int stops, rvs, busys;
    stops = 0; rvs = 0; busys = 0;
    for (int i = 0; i < n; i++) begin
      if (stop_signal !== 1'b0) stops++;
      if (result_valid !== 1'b0) rvs++;
      if (busy !== 1'b0) busys++;
      @(negedge clock);
    end
    chk({tag, "_stop_cycles"}, stops, 0);
    chk({tag, "_results"}, rvs, 0);
    chk({tag, "_busy_cycles"}, busys, 0);
  endtask

  task automatic ignored_commit(input string tag, input int p);
    player_choice = 2'(p);
    player_commit = 1'b1;
    @(negedge clock);
    player_commit = 1'b0;
    expect_quiet(tag, 10);
    chk_status(tag);
  endtask

  task automatic abort_round(input bit by_reset);
    player_choice = 2'd2;
    player_commit = 1'b1;
    computer_choice = 2'd1;
    @(negedge clock);
    player_commit = 1'b0;
    chk("abort_lock1_stop", stop_signal, 1);
    @(negedge clock);
    chk("abort_lock2_stop", stop_signal, 1);
    if (by_reset) begin
      reset_n = 1'b0;
      #1;
      chk("reset_async_stop", stop_signal, 0);
      @(negedge clock);
      reset_n = 1'b1;
    end else begin
      new_match = 1'b1;
      @(negedge clock);
      new_match = 1'b0;
      chk("abort_nm_stop", stop_signal, 0);
    end
    model_clear();
    expect_quiet(by_reset ? "abort_reset" : "abort_nm", 20);
    chk_status(by_reset ? "abort_reset" : "abort_nm");
  endtask

  initial begin
    int p;
    int v[4];
    model_clear();
    repeat (2) @(negedge clock);
    chk("reset_stop", stop_signal, 0);
    chk("reset_rv", result_valid, 0);
    chk("reset_busy", busy, 0);
    chk_status("reset");
    reset_n = 1'b1;
    @(negedge clock);

    play(1, 3, 3, 3, 3, 1'b0);
    pulse_new_match(1'b0);
    play(2, 2, 2, 2, 2, 1'b0);

    pulse_new_match(1'b0);
    repeat (3) play(1, 2, 2, 2, 2, 1'b0);
    chk("match_over_after_three", match_over, 1);
    chk("match_winner_computer", match_winner, 1);
    ignored_commit("done_commit", 1);
    pulse_new_match(1'b0);

    play(3, 0, 0, 0, 0, 1'b0);
    play(2, 0, 1, 3, 3, 1'b0);
    play(3, 0, 0, 0, 2, 1'b1);
    ignored_commit("unset_commit", 0);
    play(1, 1, 2, 2, 2, 1'b1);

    pulse_new_match(1'b1);
    expect_quiet("nm_with_commit", 10);

    play(2, 1, 1, 1, 1, 1'b0);
    abort_round(1'b0);
    play(3, 2, 2, 2, 2, 1'b0);
    abort_round(1'b1);

    for (int r = 0; r < 30; r++) begin
      if (m_over != 0) pulse_new_match(1'b0);
      p = int'($urandom_range(3, 1));
      for (int j = 0; j < 4; j++) begin
        v[j] = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(3, 1));
      end
      play(p, v[0], v[1], v[2], v[3], 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
